// File: rtl/sw_alloc_ctrl_if.sv
// ---------------------------------------------------------------------------
// sw_alloc_ctrl_if
// Bundle between the router input/output port logic and the switch allocator.
//   master : port logic side (drives requests, transfers, credits)
//   slave  : allocator side (drives grants, output locks, crossbar selects)
// Signals:
//   i_req       per-input flit waiting for the switch
//   i_target    per-input requested output, slice [i*PORT_W +: PORT_W]
//   i_out_ready per-output downstream credit available
//   i_xfer      per-input flit crossed the switch this cycle
//   i_tail      per-input qualifier: transferred flit is a tail
//   o_grant     per-input ownership of an output
//   o_out_lock  per-output locked flag
//   o_out_sel   per-output owner index (0 when unlocked)
//   o_err       sticky transfer-without-grant flag
//   o_stall_cnt saturating stall-cycle counter
// ---------------------------------------------------------------------------
interface sw_alloc_ctrl_if #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_W    = 3,
    parameter int STALL_W   = 16
);
    logic [NUM_PORTS-1:0]        i_req;
    logic [NUM_PORTS*PORT_W-1:0] i_target;
    logic [NUM_PORTS-1:0]        i_out_ready;
    logic [NUM_PORTS-1:0]        i_xfer;
    logic [NUM_PORTS-1:0]        i_tail;
    logic [NUM_PORTS-1:0]        o_grant;
    logic [NUM_PORTS-1:0]        o_out_lock;
    logic [NUM_PORTS*PORT_W-1:0] o_out_sel;
    logic                        o_err;
    logic [STALL_W-1:0]          o_stall_cnt;

    modport master (
        output i_req, i_target, i_out_ready, i_xfer, i_tail,
        input  o_grant, o_out_lock, o_out_sel, o_err, o_stall_cnt
    );

    modport slave (
        input  i_req, i_target, i_out_ready, i_xfer, i_tail,
        output o_grant, o_out_lock, o_out_sel, o_err, o_stall_cnt
    );
endinterface

// File: rtl/sw_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// sw_alloc_ctrl
// Wormhole switch allocator. Each output port runs an IDLE/LOCKED machine:
// while IDLE it round-robin arbitrates among unowned inputs whose head flit
// targets it (and only when it has downstream credit); once granted it stays
// locked to the owner until the owner's tail flit crosses the switch.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  sw_alloc_ctrl_if.slave (requests in, grants/selects/debug out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module sw_alloc_ctrl #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_W    = 3,
    parameter int STALL_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    sw_alloc_ctrl_if.slave bus
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_e;

    out_state_e                       state_q [NUM_PORTS];
    out_state_e                       state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]             grant_q, grant_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0] sel_q, sel_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0] rr_q, rr_d;
    logic                             err_q, err_d;
    logic [STALL_W-1:0]               stall_q, stall_d;

    // cand_s[j][i]: input i is an arbitration candidate for output j
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] cand_s;
    logic [NUM_PORTS-1:0]                won_s;
    logic                                stall_s;
    logic [NUM_PORTS-1:0]                lock_s;

    // Candidate matrix: requesting, not already owning, and routed to output j.
    // Out-of-range targets never match any j, so they are never candidates.
    always_comb begin
        cand_s = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand_s[j][i] = bus.i_req[i] & ~grant_q[i] &
                    (bus.i_target[i*PORT_W +: PORT_W] == PORT_W'(j));
            end
        end
    end

    // Per-output next state: tail release when locked, round-robin allocation when idle.
    always_comb begin
        logic                 done_v;
        logic                 found_v;
        logic [PORT_W-1:0]    win_v;
        logic [NUM_PORTS-1:0] rel_v;

        done_v  = 1'b0;
        found_v = 1'b0;
        win_v   = '0;
        rel_v   = '0;
        won_s   = '0;
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;

        for (int j = 0; j < NUM_PORTS; j++) begin
            done_v  = 1'b0;
            found_v = 1'b0;
            win_v   = '0;
            if (state_q[j] == ST_LOCKED) begin
                // Lock ignores credit and the owner's i_req; only its tail frees it.
                for (int i = 0; i < NUM_PORTS; i++) begin
                    done_v = done_v | ((sel_q[j] == PORT_W'(i)) & bus.i_xfer[i] & bus.i_tail[i]);
                end
                if (done_v) begin
                    state_d[j] = ST_IDLE;
                    sel_d[j]   = '0;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        rel_v[i] = rel_v[i] | (sel_q[j] == PORT_W'(i));
                    end
                end else begin
                    state_d[j] = ST_LOCKED;
                end
            end else begin
                // Round-robin as two priority passes: first candidates at or
                // above the pointer, then wrap around to the lowest candidate.
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (!found_v && cand_s[j][i] && (PORT_W'(i) >= rr_q[j])) begin
                        found_v = 1'b1;
                        win_v   = PORT_W'(i);
                    end else begin
                        found_v = found_v;
                    end
                end
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (!found_v && cand_s[j][i]) begin
                        found_v = 1'b1;
                        win_v   = PORT_W'(i);
                    end else begin
                        found_v = found_v;
                    end
                end
                if (found_v && bus.i_out_ready[j]) begin
                    state_d[j] = ST_LOCKED;
                    sel_d[j]   = win_v;
                    rr_d[j]    = (win_v == PORT_W'(NUM_PORTS - 1)) ? '0 : win_v + PORT_W'(1);
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        won_s[i] = won_s[i] | (win_v == PORT_W'(i));
                    end
                end else begin
                    state_d[j] = ST_IDLE;
                end
            end
        end
        // A winner never holds a grant, so release and allocation never hit the same bit.
        grant_d = (grant_q & ~rel_v) | won_s;
    end

    // Stall detect: a routable, unowned requester that did not win this cycle.
    always_comb begin
        stall_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            stall_s = stall_s | (bus.i_req[i] & ~grant_q[i] & ~won_s[i] &
                (bus.i_target[i*PORT_W +: PORT_W] < PORT_W'(NUM_PORTS)));
        end
    end

    // Debug next state: sticky error and saturating stall counter.
    always_comb begin
        err_d = err_q | (|(bus.i_xfer & ~grant_q));
        if (stall_s && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                state_q[j] <= ST_IDLE;
            end
            grant_q <= '0;
            sel_q   <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                state_q[j] <= state_d[j];
            end
            grant_q <= grant_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    // Lock flags are a direct decode of the per-output state registers.
    always_comb begin
        lock_s = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            lock_s[j] = (state_q[j] == ST_LOCKED);
        end
    end

    assign bus.o_grant     = grant_q;
    assign bus.o_out_lock  = lock_s;
    assign bus.o_out_sel   = sel_q;
    assign bus.o_err       = err_q;
    assign bus.o_stall_cnt = stall_q;

endmodule

// File: tb/tb_sw_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sw_alloc_ctrl
// Directed bench: a per-cycle vector table for the basic allocation, credit,
// lock, release and error behaviour, then hand sequences for round-robin
// order, asynchronous reset mid-packet and stall-counter saturation (on a
// second instance with a 4-bit counter).
// ---------------------------------------------------------------------------
module tb_sw_alloc_ctrl;

    localparam int NP = 5;
    localparam int PW = 3;

    logic clk;
    logic rst;

    sw_alloc_ctrl_if #(.NUM_PORTS(NP), .PORT_W(PW), .STALL_W(16)) bus();
    sw_alloc_ctrl_if #(.NUM_PORTS(NP), .PORT_W(PW), .STALL_W(4))  bus_s();

    sw_alloc_ctrl #(.NUM_PORTS(NP), .PORT_W(PW), .STALL_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sw_alloc_ctrl #(.NUM_PORTS(NP), .PORT_W(PW), .STALL_W(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  req;
        logic [14:0] tgt;
        logic [4:0]  rdy;
        logic [4:0]  xfer;
        logic [4:0]  tail;
        logic [4:0]  grant;
        logic [4:0]  lock;
        logic [14:0] sel;
        logic        err;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs [16];
    int   errors = 0;
    int   checks = 0;

    // Pack five 3-bit port indices, element 0 in the low slice.
    function automatic logic [14:0] pk(input int a, input int b, input int c, input int d, input int e);
        return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] req, input logic [14:0] tgt, input logic [4:0] rdy,
                         input logic [4:0] xfer, input logic [4:0] tail);
        bus.i_req       = req;
        bus.i_target    = tgt;
        bus.i_out_ready = rdy;
        bus.i_xfer      = xfer;
        bus.i_tail      = tail;
    endtask

    int order [6];
    int exp_in;

    initial begin
        order = '{0, 1, 3, 0, 1, 3};

        //           req       tgt                rdy       xfer      tail      grant     lock      sel               err   stall
        vecs[0]  = '{5'b00100, pk(7,7,4,7,7), 5'b11111, 5'b00000, 5'b00000, 5'b00100, 5'b10000, pk(0,0,0,0,2), 1'b0, 16'd0};
        vecs[1]  = '{5'b00100, pk(7,7,4,7,7), 5'b11111, 5'b00100, 5'b00000, 5'b00100, 5'b10000, pk(0,0,0,0,2), 1'b0, 16'd0};
        vecs[2]  = '{5'b00100, pk(7,7,4,7,7), 5'b11111, 5'b00100, 5'b00000, 5'b00100, 5'b10000, pk(0,0,0,0,2), 1'b0, 16'd0};
        vecs[3]  = '{5'b00000, pk(7,7,4,7,7), 5'b11111, 5'b00100, 5'b00100, 5'b00000, 5'b00000, pk(0,0,0,0,0), 1'b0, 16'd0};
        vecs[4]  = '{5'b00110, pk(7,0,3,7,7), 5'b11110, 5'b00000, 5'b00000, 5'b00100, 5'b01000, pk(0,0,0,2,0), 1'b0, 16'd1};
        vecs[5]  = '{5'b00110, pk(7,0,3,7,7), 5'b11110, 5'b00000, 5'b00000, 5'b00100, 5'b01000, pk(0,0,0,2,0), 1'b0, 16'd2};
        vecs[6]  = '{5'b00110, pk(7,0,3,7,7), 5'b11110, 5'b00000, 5'b00000, 5'b00100, 5'b01000, pk(0,0,0,2,0), 1'b0, 16'd3};
        vecs[7]  = '{5'b00110, pk(7,0,3,7,7), 5'b11111, 5'b00000, 5'b00000, 5'b00110, 5'b01001, pk(1,0,0,2,0), 1'b0, 16'd3};
        vecs[8]  = '{5'b01000, pk(7,0,3,0,7), 5'b11110, 5'b00000, 5'b00000, 5'b00110, 5'b01001, pk(1,0,0,2,0), 1'b0, 16'd4};
        vecs[9]  = '{5'b01000, pk(7,0,3,0,7), 5'b11111, 5'b00000, 5'b00000, 5'b00110, 5'b01001, pk(1,0,0,2,0), 1'b0, 16'd5};
        vecs[10] = '{5'b01000, pk(7,0,3,0,7), 5'b11111, 5'b00110, 5'b00110, 5'b00000, 5'b00000, pk(0,0,0,0,0), 1'b0, 16'd6};
        vecs[11] = '{5'b01000, pk(7,0,3,0,7), 5'b11111, 5'b00000, 5'b00000, 5'b01000, 5'b00001, pk(3,0,0,0,0), 1'b0, 16'd6};
        vecs[12] = '{5'b00000, pk(7,0,3,0,7), 5'b11111, 5'b01000, 5'b01000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 1'b0, 16'd6};
        vecs[13] = '{5'b00000, pk(7,7,7,7,7), 5'b11111, 5'b10000, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 1'b1, 16'd6};
        vecs[14] = '{5'b00000, pk(7,7,7,7,7), 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 1'b1, 16'd6};
        vecs[15] = '{5'b10000, pk(7,7,7,7,5), 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 1'b1, 16'd6};

        rst = 1'b1;
        drive(5'b00000, pk(7,7,7,7,7), 5'b00000, 5'b00000, 5'b00000);
        bus_s.i_req       = 5'b00000;
        bus_s.i_target    = pk(7,7,7,7,7);
        bus_s.i_out_ready = 5'b00000;
        bus_s.i_xfer      = 5'b00000;
        bus_s.i_tail      = 5'b00000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        chk("reset grant", 32'(bus.o_grant), 32'd0);
        chk("reset lock", 32'(bus.o_out_lock), 32'd0);
        chk("reset sel", 32'(bus.o_out_sel), 32'd0);
        chk("reset err", 32'(bus.o_err), 32'd0);
        chk("reset stall", 32'(bus.o_stall_cnt), 32'd0);

        // Table-driven cycles
        for (int v = 0; v < 16; v++) begin
            drive(vecs[v].req, vecs[v].tgt, vecs[v].rdy, vecs[v].xfer, vecs[v].tail);
            step();
            chk($sformatf("v%0d grant", v), 32'(bus.o_grant), 32'(vecs[v].grant));
            chk($sformatf("v%0d lock", v), 32'(bus.o_out_lock), 32'(vecs[v].lock));
            chk($sformatf("v%0d sel", v), 32'(bus.o_out_sel), 32'(vecs[v].sel));
            chk($sformatf("v%0d err", v), 32'(bus.o_err), 32'(vecs[v].err));
            chk($sformatf("v%0d stall", v), 32'(bus.o_stall_cnt), 32'(vecs[v].stall));
        end

        // Round-robin: inputs 0,1,3 keep requesting output 1 with single-flit packets
        for (int p = 0; p < 6; p++) begin
            exp_in = order[p];
            drive(5'b01011, pk(1,1,7,1,7), 5'b11111, 5'b00000, 5'b00000);
            step();
            chk($sformatf("rr%0d grant", p), 32'(bus.o_grant), 32'(1) << exp_in);
            chk($sformatf("rr%0d lock", p), 32'(bus.o_out_lock), 32'b00010);
            chk($sformatf("rr%0d sel", p), 32'(bus.o_out_sel), 32'(pk(0, exp_in, 0, 0, 0)));
            drive(5'b01011, pk(1,1,7,1,7), 5'b11111, 5'(1 << exp_in), 5'(1 << exp_in));
            step();
            chk($sformatf("rr%0d free", p), 32'(bus.o_out_lock), 32'd0);
        end
        // Pointer now at 4: input 4 beats input 0
        drive(5'b10001, pk(1,7,7,7,1), 5'b11111, 5'b00000, 5'b00000);
        step();
        chk("rr ptr grant", 32'(bus.o_grant), 32'b10000);
        chk("rr ptr sel", 32'(bus.o_out_sel), 32'(pk(0,4,0,0,0)));
        drive(5'b00000, pk(7,7,7,7,7), 5'b11111, 5'b10000, 5'b10000);
        step();
        chk("rr ptr free", 32'(bus.o_out_lock), 32'd0);

        // Asynchronous reset in the middle of a packet
        drive(5'b00100, pk(7,7,4,7,7), 5'b11111, 5'b00000, 5'b00000);
        step();
        chk("pre-rst grant", 32'(bus.o_grant), 32'b00100);
        drive(5'b00100, pk(7,7,4,7,7), 5'b11111, 5'b00100, 5'b00000);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst grant", 32'(bus.o_grant), 32'd0);
        chk("async rst lock", 32'(bus.o_out_lock), 32'd0);
        chk("async rst sel", 32'(bus.o_out_sel), 32'd0);
        chk("async rst err", 32'(bus.o_err), 32'd0);
        chk("async rst stall", 32'(bus.o_stall_cnt), 32'd0);
        drive(5'b00100, pk(7,7,4,7,7), 5'b11111, 5'b00000, 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post-rst grant", 32'(bus.o_grant), 32'b00100);
        chk("post-rst sel", 32'(bus.o_out_sel), 32'(pk(0,0,0,0,2)));
        drive(5'b00000, pk(7,7,4,7,7), 5'b11111, 5'b00100, 5'b00100);
        step();
        chk("post-rst free", 32'(bus.o_out_lock), 32'd0);

        // Stall saturation on the 4-bit counter instance: input 1 starved of credit
        bus_s.i_req       = 5'b00010;
        bus_s.i_target    = pk(7,0,7,7,7);
        bus_s.i_out_ready = 5'b11110;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 9) begin
                chk("sat mid", 32'(bus_s.o_stall_cnt), 32'd10);
            end
        end
        chk("sat end", 32'(bus_s.o_stall_cnt), 32'd15);
        chk("sat no grant", 32'(bus_s.o_grant), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
